mux_scan_n: RTL and testbench

MUX_SCAN_N -- requirements
Module: mux_scan_n

---
 rtl/mux_scan_n.sv | 62 ++++++
 tb/tb_mux_scan_n.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// Registered N-way channel mux with manual select and an auto-scan mode that
// dwells dwell+1 cycles per channel; chg pulses whenever the index moves.
module mux_scan_n #(
  parameter int W    = 8,
  parameter int SELW = 2,
  parameter int CW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(2**SELW)*W-1:0]    din,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CW-1:0]             dwell,
  input  logic                      hold,
  output logic [W-1:0]              dout,
  output logic [SELW-1:0]           sel_out,
  output logic                      chg
);

  localparam int N = 2**SELW;

  typedef struct packed {
    logic [SELW-1:0] sel;
    logic [CW-1:0]   cnt;
  } scan_t;

  logic [N-1:0][W-1:0] ch;
  scan_t               cur, nxt;

  assign ch = din;

  // cnt only increments while below dwell, so it can never wrap.
  always_comb begin
    nxt = cur;
    if (!mode) begin
      nxt.sel = sel_in;
      nxt.cnt = '0;
    end else if (!hold) begin
      if (cur.cnt >= dwell) begin
        nxt.sel = cur.sel + SELW'(1);
        nxt.cnt = '0;
      end else begin
        nxt.cnt = cur.cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur  <= '0;
      dout <= '0;
      chg  <= 1'b0;
    end else begin
      cur  <= nxt;
      dout <= ch[cur.sel];
      chg  <= (nxt.sel != cur.sel);
    end
  end

  assign sel_out = cur.sel;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized plus directed bench for mux_scan_n against a cycle model built
// from the channel-scan rules with plain integer arithmetic.
module tb_mux_scan_n;
  localparam int W = 8, SELW = 2, CW = 8, N = 4;

  logic            clk = 0, rst = 1;
  logic [N*W-1:0]  din = 32'h44332211;
  logic            mode = 0, hold = 0;
  logic [SELW-1:0] sel_in = 0;
  logic [CW-1:0]   dwell = 0;
  logic [W-1:0]    dout;
  logic [SELW-1:0] sel_out;
  logic            chg;

  int n_tests = 0, n_fail = 0;
  int m_sel = 0, m_cnt = 0, m_dout = 0, m_chg = 0;

  mux_scan_n #(.W(W), .SELW(SELW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .sel_in(sel_in),
    .dwell(dwell), .hold(hold), .dout(dout), .sel_out(sel_out), .chg(chg));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".sel"},  int'(sel_out), m_sel);
    chk({tag, ".dout"}, int'(dout),    m_dout);
    chk({tag, ".chg"},  int'(chg),     m_chg);
  endtask

  // One rising edge: apply the scan rules to the model, then compare.
  task automatic step(input string tag);
    int ns;
    @(posedge clk);
    if (rst) begin
      m_sel = 0; m_cnt = 0; m_dout = 0; m_chg = 0;
    end else begin
      m_dout = int'((din >> (m_sel * W)) & 32'hff);
      ns = m_sel;
      if (!mode) begin
        ns = sel_in; m_cnt = 0;
      end else if (!hold) begin
        if (m_cnt >= dwell) begin
          ns = (m_sel + 1) % N; m_cnt = 0;
        end else m_cnt = m_cnt + 1;
      end
      m_chg = (ns != m_sel) ? 1 : 0;
      m_sel = ns;
    end
    #1;
    chk_outs(tag);
  endtask

  // Async reset pulse between edges; outputs must clear before the next edge.
  task automatic pulse_rst(input string tag);
    #1 rst = 1;
    #1;
    m_sel = 0; m_cnt = 0; m_dout = 0; m_chg = 0;
    chk_outs(tag);
    rst = 0;
  endtask

  int seq29[12] = '{0,0,1,1,1,2,2,2,3,3,3,0};
  int s_before;

  initial begin
    #2;
    chk_outs("reset");
    #1 rst = 0;

    // Manual select 0 -> 2, then held
    mode = 0; sel_in = 2;
    step("man1"); chk("man1.sel_c", int'(sel_out), 2); chk("man1.chg_c", int'(chg), 1);
    step("man2"); chk("man2.dout_c", int'(dout), 8'h33); chk("man2.chg_c", int'(chg), 0);
    step("man3"); chk("man3.chg_c", int'(chg), 0);

    // Scan dwell=2 from reset
    pulse_rst("rst_a");
    mode = 1; dwell = 2;
    for (int i = 0; i < 12; i++) begin
      step("scan2");
      chk("scan2.seq", int'(sel_out), seq29[i]);
    end

    // Scan dwell=0: advance every edge
    pulse_rst("rst_b");
    dwell = 0;
    for (int i = 0; i < 5; i++) begin
      step("scan0");
      chk("scan0.seq", int'(sel_out), (i + 1) % N);
      chk("scan0.chg_c", int'(chg), 1);
    end

    // Hold for 5 cycles at cnt=2 with dwell=4
    pulse_rst("rst_c");
    dwell = 4;
    step("hold_pre"); step("hold_pre");
    hold = 1;
    for (int i = 0; i < 5; i++) begin
      step("hold");
      chk("hold.sel_c", int'(sel_out), 0); chk("hold.chg_c", int'(chg), 0);
    end
    hold = 0;
    step("hold_rel"); step("hold_rel");
    chk("hold_rel.sel_c", int'(sel_out), 0);
    step("hold_adv");
    chk("hold_adv.sel_c", int'(sel_out), 1);

    // Dwell lowered below current count
    pulse_rst("rst_d");
    dwell = 7;
    for (int i = 0; i < 5; i++) step("dw7");
    dwell = 3;
    step("dw_lower");
    chk("dw_lower.sel_c", int'(sel_out), 1);

    // Reset mid-scan at channel 2, then full dwell from channel 0
    pulse_rst("rst_e");
    dwell = 1;
    for (int i = 0; i < 4; i++) step("pre33");
    chk("pre33.sel_c", int'(sel_out), 2);
    pulse_rst("rst_mid");
    step("post33"); chk("post33.sel_c", int'(sel_out), 0);
    step("post33"); step("post33"); chk("post33.adv", int'(sel_out), 1);

    // Randomized mix of modes, holds, dwells, data and async resets
    for (int i = 0; i < 600; i++) begin
      mode   = ($urandom_range(0, 9) < 7);
      hold   = ($urandom_range(0, 3) == 0);
      sel_in = SELW'($urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) dwell = CW'($urandom_range(0, 5));
      din    = $urandom;
      s_before = m_sel;
      step("rand");
      if ($urandom_range(0, 60) == 0) pulse_rst("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
